// File: rtl/pipe_ctrl.sv
// Control-register chain Decode->Execute->Memory->Writeback with flush bubbles,
// ARM condition gating, branch resolution and a retired-instruction counter.
module pipe_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        arm,
   input  logic        FlushE,
   input  logic        RegWriteD,
   input  logic        MemWriteD,
   input  logic        PCSrcD,
   input  logic        BranchD,
   input  logic        JumpD,
   input  logic [1:0]  ResultSrcD,
   input  logic [4:0]  Rs1D,
   input  logic [4:0]  Rs2D,
   input  logic [4:0]  RdD,
   input  logic        CondExE,
   input  logic        BranchCondE,
   output logic [4:0]  Rs1E,
   output logic [4:0]  Rs2E,
   output logic [4:0]  RdE,
   output logic [4:0]  RdM,
   output logic [4:0]  RdW,
   output logic        RegWriteE,
   output logic        RegWriteM,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcE,
   output logic [1:0]  ResultSrcW,
   output logic        MemWriteM,
   output logic        PCSrcE,
   output logic        PCSrcM,
   output logic        PCSrcW,
   output logic        BranchTakenE,
   output logic        RVPCSrcE,
   output logic        ValidE,
   output logic        ValidM,
   output logic        ValidW,
   output logic [31:0] RetireCount
);

   logic       reg_write_e_q;
   logic       mem_write_e_q;
   logic       pc_src_e_q;
   logic       branch_e_q;
   logic       jump_e_q;
   logic       mem_write_e;
   logic       cond_ok;
   logic [1:0] result_src_m;

   // Decode -> Execute: a flush loads an all-zero bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset || FlushE) begin
         reg_write_e_q <= 1'b0;
         mem_write_e_q <= 1'b0;
         pc_src_e_q    <= 1'b0;
         branch_e_q    <= 1'b0;
         jump_e_q      <= 1'b0;
         ResultSrcE    <= 2'b00;
         Rs1E          <= 5'd0;
         Rs2E          <= 5'd0;
         RdE           <= 5'd0;
         ValidE        <= 1'b0;
      end else begin
         reg_write_e_q <= RegWriteD;
         mem_write_e_q <= MemWriteD;
         pc_src_e_q    <= PCSrcD;
         branch_e_q    <= BranchD;
         jump_e_q      <= JumpD;
         ResultSrcE    <= ResultSrcD;
         Rs1E          <= Rs1D;
         Rs2E          <= Rs2D;
         RdE           <= RdD;
         ValidE        <= 1'b1;
      end
   end

   // Execute-stage effective controls; RISC-V ignores the ARM condition check
   assign cond_ok      = ~arm | CondExE;
   assign RegWriteE    = reg_write_e_q & cond_ok;
   assign mem_write_e  = mem_write_e_q & cond_ok;
   assign PCSrcE       = pc_src_e_q & cond_ok;
   assign BranchTakenE = arm & branch_e_q & CondExE;
   assign RVPCSrcE     = ~arm & ValidE & (jump_e_q | (branch_e_q & BranchCondE));

   // Execute -> Memory
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         RegWriteM    <= 1'b0;
         MemWriteM    <= 1'b0;
         PCSrcM       <= 1'b0;
         result_src_m <= 2'b00;
         RdM          <= 5'd0;
         ValidM       <= 1'b0;
      end else begin
         RegWriteM    <= RegWriteE;
         MemWriteM    <= mem_write_e;
         PCSrcM       <= PCSrcE;
         result_src_m <= ResultSrcE;
         RdM          <= RdE;
         ValidM       <= ValidE;
      end
   end

   // Memory -> Writeback, plus retirement counting of instructions leaving W
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         RegWriteW   <= 1'b0;
         PCSrcW      <= 1'b0;
         ResultSrcW  <= 2'b00;
         RdW         <= 5'd0;
         ValidW      <= 1'b0;
         RetireCount <= 32'd0;
      end else begin
         RegWriteW   <= RegWriteM;
         PCSrcW      <= PCSrcM;
         ResultSrcW  <= result_src_m;
         RdW         <= RdM;
         ValidW      <= ValidM;
         if (ValidW)
            RetireCount <= RetireCount + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: E-stage vector table plus multi-cycle sequences.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        reset, arm, FlushE;
   logic        RegWriteD, MemWriteD, PCSrcD, BranchD, JumpD;
   logic [1:0]  ResultSrcD;
   logic [4:0]  Rs1D, Rs2D, RdD;
   logic        CondExE, BranchCondE;
   logic [4:0]  Rs1E, Rs2E, RdE, RdM, RdW;
   logic        RegWriteE, RegWriteM, RegWriteW;
   logic [1:0]  ResultSrcE, ResultSrcW;
   logic        MemWriteM, PCSrcE, PCSrcM, PCSrcW;
   logic        BranchTakenE, RVPCSrcE, ValidE, ValidM, ValidW;
   logic [31:0] RetireCount;

   int errors = 0;
   int checks = 0;

   pipe_ctrl dut (
      .clk(clk), .reset(reset), .arm(arm), .FlushE(FlushE),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .PCSrcD(PCSrcD),
      .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
      .CondExE(CondExE), .BranchCondE(BranchCondE),
      .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .ResultSrcW(ResultSrcW), .MemWriteM(MemWriteM),
      .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE), .RVPCSrcE(RVPCSrcE),
      .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW),
      .RetireCount(RetireCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       arm, flush, rw, mw, pcs, br, jmp;
      logic [1:0] rsrc;
      logic [4:0] rd;
      logic       cond, bcond;
      logic       e_rw, e_pcs, e_bt, e_rv, e_v;
      logic [1:0] e_rsrc;
      logic [4:0] e_rd;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] all_out();
      return {Rs1E, Rs2E, RdE, RdM, RdW, RegWriteE, RegWriteM, RegWriteW,
              ResultSrcE, ResultSrcW, MemWriteM, PCSrcE, PCSrcM, PCSrcW,
              BranchTakenE, RVPCSrcE, ValidE, ValidM, ValidW, RetireCount};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fl, rw, mw, pcs, br, jmp,
                        input logic [1:0] rs, input logic [4:0] rd);
      FlushE = fl; RegWriteD = rw; MemWriteD = mw; PCSrcD = pcs;
      BranchD = br; JumpD = jmp; ResultSrcD = rs; RdD = rd;
      Rs1D = rd + 5'd1; Rs2D = rd + 5'd2;
   endtask

   task automatic bubble();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
   endtask

   initial begin
      logic [31:0] cnt0;
      logic [4:0]  ers1, ers2;

      //                arm fl rw mw pcs br jmp rsrc   rd     cond bc | rw pcs bt rv v rsrc  rd
      vt[0]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,5'd3, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,5'd3};
      vt[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,5'd4, 1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,2'b00,5'd4};
      vt[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,5'd5, 1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,5'd5};
      vt[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,5'd6, 1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,5'd6};
      vt[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,5'd8, 1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,5'd8};
      vt[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,5'd9, 1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,5'd9};
      vt[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,5'd10,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,5'd10};
      vt[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,5'd11,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,5'd11};
      vt[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,5'd12,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,2'b01,5'd12};
      vt[9]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,2'b01,5'd7, 1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0};
      vt[10] = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,2'b01,5'd7, 1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,5'd0};
      vt[11] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,5'd15,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,2'b10,5'd15};

      // reset held with random inputs
      reset = 1'b1; arm = 1'b0; CondExE = 1'b0; BranchCondE = 1'b0;
      bubble();
      for (int i = 0; i < 3; i++) begin
         drive($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
               $urandom_range(0,1), $urandom_range(0,1), 2'($urandom_range(0,3)), 5'($urandom_range(0,31)));
         arm = $urandom_range(0,1); CondExE = $urandom_range(0,1); BranchCondE = $urandom_range(0,1);
         step();
         chk($sformatf("reset_hold%0d", i), all_out(), '0);
      end
      reset = 1'b0; arm = 1'b0; CondExE = 1'b0; BranchCondE = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd5);
      step();
      chk("first_E", {RdE, RegWriteE, ValidE}, {5'd5, 1'b1, 1'b1});
      bubble();
      step();
      chk("first_M", {RdM, RegWriteM, ValidM}, {5'd5, 1'b1, 1'b1});
      step();
      chk("first_W", {RdW, RegWriteW, ValidW}, {5'd5, 1'b1, 1'b1});
      step();
      chk("first_retire", RetireCount, 32'd1);

      // flush beats a valid D instruction
      cnt0 = RetireCount;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 5'd7);
      step();
      chk("flush_E", {RdE, ResultSrcE, ValidE, RegWriteE}, '0);
      bubble();
      step();
      step();
      chk("flush_W", {RdW, ValidW, RegWriteW}, '0);
      step();
      chk("flush_noretire", RetireCount, cnt0);

      // ARM condition failed, then passed, followed downstream
      arm = 1'b1;
      for (int c = 0; c < 2; c++) begin
         CondExE = c[0];
         drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 5'd9);
         step();
         chk($sformatf("armc%0d_E", c), {RegWriteE, PCSrcE, ValidE, RdE}, {c[0], c[0], 1'b1, 5'd9});
         bubble();
         step();
         chk($sformatf("armc%0d_M", c), {RegWriteM, PCSrcM, MemWriteM, ValidM}, {c[0], c[0], c[0], 1'b1});
         step();
         chk($sformatf("armc%0d_W", c), {RegWriteW, PCSrcW, ValidW}, {c[0], c[0], 1'b1});
      end
      CondExE = 1'b0;
      step();

      // E-stage vector table
      for (int i = 0; i < 12; i++) begin
         arm = vt[i].arm;
         CondExE = 1'b0; BranchCondE = 1'b0;
         drive(vt[i].flush, vt[i].rw, vt[i].mw, vt[i].pcs, vt[i].br, vt[i].jmp, vt[i].rsrc, vt[i].rd);
         step();
         CondExE = vt[i].cond; BranchCondE = vt[i].bcond;
         #1;
         ers1 = vt[i].flush ? 5'd0 : vt[i].rd + 5'd1;
         ers2 = vt[i].flush ? 5'd0 : vt[i].rd + 5'd2;
         chk($sformatf("vec%0d", i),
             {RegWriteE, PCSrcE, BranchTakenE, RVPCSrcE, ValidE, ResultSrcE, RdE, Rs1E, Rs2E},
             {vt[i].e_rw, vt[i].e_pcs, vt[i].e_bt, vt[i].e_rv, vt[i].e_v, vt[i].e_rsrc, vt[i].e_rd, ers1, ers2});
      end
      arm = 1'b0; CondExE = 1'b0; BranchCondE = 1'b0;

      // retire count: 10 valid, 2 flushed
      reset = 1'b1; #2; reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         drive((i == 3 || i == 7), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'(i));
         step();
      end
      bubble();
      repeat (4) step();
      chk("retire10", RetireCount, 32'd10);

      // counter wrap
      force dut.RetireCount = 32'hFFFF_FFFF;
      #1;
      release dut.RetireCount;
      #1;
      chk("wrap_preset", RetireCount, 32'hFFFF_FFFF);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd4);
      step();
      bubble();
      step();
      step();
      chk("wrap_hold", RetireCount, 32'hFFFF_FFFF);
      step();
      chk("wrap_zero", RetireCount, 32'd0);

      // asynchronous reset with three instructions in flight
      for (int i = 1; i <= 3; i++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 5'(i));
         step();
      end
      chk("inflight", {ValidE, ValidM, ValidW, RdE, RdM, RdW}, {3'b111, 5'd3, 5'd2, 5'd1});
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset", all_out(), '0);
      #1;
      bubble();
      step();
      reset = 1'b0;
      #1;
      chk("after_reset", all_out(), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control-register chain for the combined ARM/RISC-V core. Carries decoded control fields from Decode through Execute, Memory and Writeback, applying the hazard unit's stall/flush commands. Supplies the hazard unit with the per-stage destination, source and write-enable fields and the resolved branch signals it needs. Also counts retired instructions.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- arm  in  1  ISA select (1 = ARM, 0 = RISC-V); quasi-static
- FlushE  in  1  insert bubble into Execute register
- RegWriteD, MemWriteD, PCSrcD, BranchD, JumpD  in  1 each  decoded controls (PCSrcD ARM only, JumpD RISC-V only)
- ResultSrcD  in  2  result select (bit 1 RISC-V only)
- Rs1D, Rs2D, RdD  in  5 each  register fields (ARM uses [3:0], bit 4 = 0)
- CondExE  in  1  ARM condition-check pass for the Execute instruction
- BranchCondE  in  1  RISC-V branch comparison true
- Rs1E, Rs2E, RdE, RdM, RdW  out  5 each  staged register fields
- RegWriteE, RegWriteM, RegWriteW  out  1 each  effective register write per stage
- ResultSrcE, ResultSrcW  out  2 each  staged result select
- MemWriteM  out  1  effective memory write
- PCSrcE, PCSrcM, PCSrcW  out  1 each  effective ARM PC write per stage
- BranchTakenE, RVPCSrcE  out  1 each  resolved ARM branch / RISC-V redirect
- ValidE, ValidM, ValidW  out  1 each  stage holds a real instruction
- RetireCount  out  32  number of valid instructions that have left Writeback

## Operation
- E register: FlushE=1 → load bubble (all controls, valid and register fields 0); otherwise load the D inputs with ValidE=1. There is no separate stall: under a load stall the hazard unit asserts FlushE, so a stalled D instruction never double-enters E.
- M and W registers load unconditionally every cycle from the preceding stage's effective values.
- Effective E-stage gating, arm=1: RegWrite, MemWrite and PCSrc are each ANDed with CondExE. With arm=0, CondExE is ignored.
- BranchTakenE = arm & BranchE & CondExE.
- RVPCSrcE = ~arm & ValidE & (JumpE | (BranchE & BranchCondE)).
- ResultSrcE output is the ungated registered value; the hazard unit uses bit 0 for load-use detection.
- A bubble has RdE=0 and ResultSrcE=0, so it cannot cause a load stall or a forward.
- RetireCount increments by 1 each cycle ValidW=1.
  - Includes ARM instructions whose condition failed, since they are valid but non-writing.
  - Wraps modulo 2^32.
- A flushed or bubbled stage never writes registers or memory and never redirects the PC.

## Timing
- Reset (asynchronous assert): every output 0, including RetireCount. First instruction may enter E on the first rising edge after reset deasserts.
- Latency: D fields appear on E outputs 1 cycle later, M 2 cycles, W 3 cycles.
- BranchTakenE, RVPCSrcE and the E-stage effective writes are combinational from the E register and the same-cycle CondExE/BranchCondE. No registered delay.
- FlushE and a valid D instruction in the same cycle: the flush wins and the D instruction is dropped from E.
- Reset mid-stream: all in-flight stages are discarded immediately. Nothing retires; the counter is cleared.
- arm changes only while the pipeline is empty. Behaviour with in-flight instructions across an arm change is undefined.

## Test plan
- Reset check: hold reset with random D inputs for 3 cycles. All outputs stay 0; after release, RdD=5 and RegWriteD=1 appear as RdE=5/RegWriteE=1 on cycle 1, RdM=5 on cycle 2, and RdW=5/RegWriteW=1 on cycle 3.
- Flush: RdD=7, ResultSrcD=01, FlushE=1 for one cycle. Next cycle RdE=0, ResultSrcE=00, ValidE=0. That bubble reaches W 2 cycles later and RetireCount does not increment for it.
- ARM conditional: arm=1, RegWriteD=1, PCSrcD=1, CondExE=0 in E. Then RegWriteE=0 and PCSrcE=0, and RegWriteM/W and PCSrcM/W stay 0 downstream. Repeat with CondExE=1: PCSrcE, PCSrcM and PCSrcW each assert in successive cycles.
- Branches:
  - arm=1, BranchD=1, CondExE=1 → BranchTakenE=1, RVPCSrcE=0.
  - arm=0, BranchD=1, BranchCondE=0 → RVPCSrcE=0; with BranchCondE=1 → RVPCSrcE=1.
  - arm=0, JumpD=1 → RVPCSrcE=1 regardless of BranchCondE.
- Retire count and wrap: stream 10 valid instructions with 2 interleaved flushes → RetireCount=10. Force the counter to 0xFFFFFFFF, then retire one more → 0x00000000.
- Asynchronous reset mid-stream: assert reset between clock edges with 3 instructions in flight. All outputs go to 0 before the next edge; no retire occurs.
